// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    localparam int XLEN = 32;
    localparam int ILEN = 32;

    localparam logic [ILEN-1:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // One buffered instruction together with the address it was fetched from.
    typedef struct packed {
        logic [ILEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

    // Force an address onto a word boundary.
    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] a);
        return a & ~XLEN'(3);
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of fetch entries with flush; QDEPTH must be a power of two.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int QDEPTH = 2,
    parameter int CNT_W  = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  fetch_entry_t     push_data,
    input  logic             pop,
    input  logic             flush,
    output fetch_entry_t     head,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full
);

    localparam int               PTR_W   = $clog2(QDEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(QDEPTH);

    fetch_entry_t     mem_q [QDEPTH];
    fetch_entry_t     mem_d [QDEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             pop_fire;
    logic             push_fire;

    assign empty = (count_q == '0);
    assign full  = (count_q == DEPTH_C);
    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

    // Qualify push/pop; a push into a full queue is only taken when a pop frees the slot.
    always_comb begin
        pop_fire  = pop && !empty;
        push_fire = push && !flush && (!full || pop_fire);
    end

    // Pointer and occupancy update; flush empties the queue and wins over push/pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_fire) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_fire)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push_fire, pop_fire})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Storage write for an accepted push.
    always_comb begin
        mem_d = mem_q;
        if (push_fire) mem_d[wr_ptr_q] = push_data;
    end

    // Control state, cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are only meaningful under the occupancy count.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC, credit-limited memory requests, response queue, redirects.
// Optional feature macro IFETCH_MISALIGN_CHK_EN adds misaligned_err and halts fetch
// after a redirect to an unaligned target until an aligned redirect arrives.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int              QDEPTH   = 2,
    parameter int              CNT_W    = 3
) (
    input  logic            clk,
    input  logic            rst,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [XLEN-1:0] mem_req_addr,
    input  logic            mem_rsp_valid,
    input  logic [ILEN-1:0] mem_rsp_data,
    output logic [ILEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    output logic            instr_valid,
    input  logic            instr_ready,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc
`ifdef IFETCH_MISALIGN_CHK_EN
    ,
    output logic            misaligned_err
`endif
);

    localparam int               PTR_W    = $clog2(QDEPTH);
    localparam logic [CNT_W:0]   DEPTH_CR = (CNT_W+1)'(QDEPTH);

    logic [XLEN-1:0]  pc_q, pc_d;
    logic [CNT_W-1:0] out_q, out_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic             err_q, err_d;

    // In-flight request addresses, popped in order as responses return.
    logic [XLEN-1:0]  pcf_q [QDEPTH];
    logic [XLEN-1:0]  pcf_d [QDEPTH];
    logic [PTR_W-1:0] pcf_wr_q, pcf_wr_d;
    logic [PTR_W-1:0] pcf_rd_q, pcf_rd_d;

    logic             req_fire;
    logic             rsp_drop;
    logic             rsp_push;
    logic             halt;
    logic [CNT_W:0]   credit_sum;
    logic             q_pop;
    fetch_entry_t     q_head;
    fetch_entry_t     q_push_data;
    logic [CNT_W-1:0] q_count;
    logic             q_empty;
    logic             q_full;

    fetch_queue #(
        .QDEPTH (QDEPTH),
        .CNT_W  (CNT_W)
    ) u_queue (
        .clk       (clk),
        .rst_n     (rst),
        .push      (rsp_push),
        .push_data (q_push_data),
        .pop       (q_pop),
        .flush     (redirect_valid),
        .head      (q_head),
        .count     (q_count),
        .empty     (q_empty),
        .full      (q_full)
    );

`ifdef IFETCH_MISALIGN_CHK_EN
    assign misaligned_err = err_q;
    assign halt           = err_q;
`else
    logic redirect_lo_unused;
    assign redirect_lo_unused = ^{redirect_pc[1:0], err_q};
    assign halt               = 1'b0;
`endif

    // Decoder side: head of queue, or NOP/0 when nothing is buffered.
    always_comb begin
        instr_valid = !q_empty;
        q_pop       = instr_valid && instr_ready;
        instr       = instr_valid ? q_head.instr : NOP_INSTR;
        instr_pc    = instr_valid ? q_head.pc    : '0;
    end

    // Request credit: in-flight plus buffered words stay within QDEPTH; a word
    // leaving the queue this cycle frees its slot immediately so a 1-cycle
    // memory can sustain one fetch per cycle.
    always_comb begin
        credit_sum    = {1'b0, out_q} + {1'b0, q_count} - {{CNT_W{1'b0}}, q_pop};
        mem_req_valid = rst && !halt && (credit_sum < DEPTH_CR);
        mem_req_addr  = align_word(pc_q);
        req_fire      = mem_req_valid && mem_req_ready;
    end

    // Response routing: stale words are counted off; live words enter the queue tagged with their PC.
    always_comb begin
        rsp_drop          = mem_rsp_valid && (drop_q != '0);
        rsp_push          = mem_rsp_valid && !rsp_drop;
        q_push_data.instr = mem_rsp_data;
        q_push_data.pc    = pcf_q[pcf_rd_q];
    end

    // Outstanding/drop counters; on redirect everything still in flight after this edge is stale.
    always_comb begin
        out_d = out_q + {{(CNT_W-1){1'b0}}, req_fire} - {{(CNT_W-1){1'b0}}, mem_rsp_valid};
        if (redirect_valid) begin
            drop_d = out_d;
        end else begin
            drop_d = drop_q - {{(CNT_W-1){1'b0}}, rsp_drop};
        end
    end

    // PC and error flag; redirect wins over the sequential increment.
    always_comb begin
        pc_d  = pc_q;
        err_d = err_q;
        if (redirect_valid) begin
            pc_d  = align_word(redirect_pc);
            err_d = (redirect_pc[1:0] != 2'b00);
        end else if (req_fire) begin
            pc_d = pc_q + XLEN'(4);
        end
    end

    // In-flight PC FIFO: push the issued address, pop on every response, never flushed.
    always_comb begin
        pcf_d    = pcf_q;
        pcf_wr_d = pcf_wr_q;
        pcf_rd_d = pcf_rd_q;
        if (req_fire) begin
            pcf_d[pcf_wr_q] = pc_q;
            pcf_wr_d        = pcf_wr_q + PTR_W'(1);
        end
        if (mem_rsp_valid) pcf_rd_d = pcf_rd_q + PTR_W'(1);
    end

    // Control state with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q     <= RESET_PC;
            out_q    <= '0;
            drop_q   <= '0;
            err_q    <= 1'b0;
            pcf_wr_q <= '0;
            pcf_rd_q <= '0;
        end else begin
            pc_q     <= pc_d;
            out_q    <= out_d;
            drop_q   <= drop_d;
            err_q    <= err_d;
            pcf_wr_q <= pcf_wr_d;
            pcf_rd_q <= pcf_rd_d;
        end
    end

    // In-flight address storage, qualified by the FIFO pointers.
    always_ff @(posedge clk) begin
        pcf_q <= pcf_d;
    end

`ifndef SYNTHESIS
    a_no_rsp_into_full: assert property (@(posedge clk) disable iff (!rst) !(mem_rsp_valid && q_full));
    a_rsp_has_request:  assert property (@(posedge clk) disable iff (!rst) !(mem_rsp_valid && (out_q == '0)));
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Randomised scoreboard bench for instr_fetch with an in-order variable-latency memory model.
module tb_instr_fetch;

    localparam int          QD     = 2;
    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic [31:0] mem_req_addr;
    logic        mem_rsp_valid = 1'b0;
    logic [31:0] mem_rsp_data = 32'h0;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
`ifdef IFETCH_MISALIGN_CHK_EN
    logic        misaligned_err;
`endif

    always #5 clk = ~clk;

    instr_fetch #(.RESET_PC(RST_PC), .QDEPTH(QD), .CNT_W(3)) dut (
        .clk            (clk),
        .rst            (rst),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_rsp_valid  (mem_rsp_valid),
        .mem_rsp_data   (mem_rsp_data),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
`ifdef IFETCH_MISALIGN_CHK_EN
        ,
        .misaligned_err (misaligned_err)
`endif
    );

    typedef struct { logic [31:0] addr; int due; }            mreq_t;
    typedef struct { logic [31:0] addr; int epoch; }          flight_t;
    typedef struct { logic [31:0] instr; logic [31:0] pc; }   exp_t;

    mreq_t   mq[$];   // memory: accepted requests awaiting their response slot
    flight_t fl[$];   // model: requests in flight, tagged with the redirect epoch at issue
    exp_t    sb[$];   // model: words the decoder should see, in order

    int checks = 0, passes = 0, cyc = 0;
    logic [31:0] m_pc = RST_PC;
    int  epoch = 0;
    bit  halt = 1'b0;
    int  rdy_mode = 0, irdy_mode = 0, lat_min = 1, lat_max = 1, redir_rate = 0;
    bit  redir_go = 1'b0, rel_pending = 1'b0;
    logic [31:0] redir_tgt = 32'h0;
    bit  watch_on = 1'b0;
    logic [31:0] watch_pc = 32'h0;
    int  pops = 0, accepts = 0, first_acc_cyc = -1, first_valid_cyc = -1;
    bit  last_acc = 1'b0, last_rsp = 1'b0;

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (ok) passes++;
        else $display("FAIL %s: actual %h required %h (cycle %0d)", name, act, req, cyc);
    endtask

    // Monitor: compares the decoder-side output against the scoreboard each cycle.
    always @(negedge clk) begin : monitor
        exp_t e;
        #1;
        chk(instr_valid == (sb.size() != 0), "instr_valid", {31'b0, instr_valid}, {31'b0, sb.size() != 0});
        if (instr_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (instr_valid) begin
            if (instr_ready && sb.size() != 0) begin
                e = sb.pop_front();
                chk(instr == e.instr, "instr", instr, e.instr);
                chk(instr_pc == e.pc, "instr_pc", instr_pc, e.pc);
                if (watch_on) begin
                    chk(instr_pc == watch_pc, "first_pc_after_redirect", instr_pc, watch_pc);
                    watch_on = 1'b0;
                end
                pops++;
            end
        end else begin
            chk(instr == NOP, "idle_instr_nop", instr, NOP);
            chk(instr_pc == 32'h0, "idle_instr_pc", instr_pc, 32'h0);
        end
    end

    // One clock of stimulus plus model update for what the next rising edge does.
    task automatic step();
        bit acc, rsp, do_redir, use_go, exp_v;
        mreq_t m;
        flight_t f;
        logic [31:0] t;
        int lat;
        @(negedge clk);
        cyc++;
        if (rel_pending) begin rst = 1'b1; rel_pending = 1'b0; end
        rsp = 1'b0;
        if (rst && mq.size() != 0 && mq[0].due <= cyc) begin
            m = mq.pop_front();
            rsp = 1'b1;
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = m.addr + 32'h100;
        end else begin
            mem_rsp_valid = 1'b0;
            mem_rsp_data  = $urandom;
        end
        case (rdy_mode)
            0:       mem_req_ready = 1'b1;
            1:       mem_req_ready = 1'($urandom_range(0, 1));
            default: mem_req_ready = ((cyc % 2) == 0);
        endcase
        case (irdy_mode)
            0:       instr_ready = 1'b1;
            1:       instr_ready = 1'($urandom_range(0, 1));
            default: instr_ready = 1'b0;
        endcase
        use_go   = redir_go;
        redir_go = 1'b0;
        do_redir = rst && (use_go || (redir_rate != 0 && $urandom_range(0, 999) < redir_rate));
        if (do_redir) begin
            if (use_go) begin
                t = redir_tgt;
            end else begin
                t = ($urandom_range(0, 7) == 0) ? 32'hffff_ffe0 : ($urandom & 32'h0000_3ffc);
                if ($urandom_range(0, 3) == 0) t[1:0] = 2'($urandom_range(1, 3));
            end
            redirect_valid = 1'b1;
            redirect_pc    = t;
        end else begin
            redirect_valid = 1'b0;
            redirect_pc    = $urandom;
        end
        #2;
        // the monitor has already popped this cycle's consumed word from sb
        exp_v = rst && !halt && ((fl.size() + sb.size()) < QD);
        chk(mem_req_valid == exp_v, "mem_req_valid", {31'b0, mem_req_valid}, {31'b0, exp_v});
        if (mem_req_valid && exp_v) chk(mem_req_addr == m_pc, "mem_req_addr", mem_req_addr, m_pc);
`ifdef IFETCH_MISALIGN_CHK_EN
        chk(misaligned_err == halt, "misaligned_err", {31'b0, misaligned_err}, {31'b0, halt});
`endif
        acc = mem_req_valid && mem_req_ready;
        if (rsp) begin
            if (fl.size() != 0) begin
                f = fl.pop_front();
                if (f.epoch == epoch) sb.push_back('{f.addr + 32'h100, f.addr});
            end else begin
                chk(1'b0, "response_without_request", 32'h1, 32'h0);
            end
        end
        if (acc) begin
            lat = $urandom_range(lat_min, lat_max);
            m.addr = mem_req_addr;
            m.due  = cyc + lat;
            if (mq.size() != 0 && m.due < mq[$].due) m.due = mq[$].due;
            mq.push_back(m);
            fl.push_back('{m_pc, epoch});
            m_pc = m_pc + 32'h4;
            accepts++;
            if (first_acc_cyc < 0) first_acc_cyc = cyc;
        end
        if (redirect_valid) begin
            sb.delete();
            epoch++;
            m_pc = redirect_pc & 32'hffff_fffc;
`ifdef IFETCH_MISALIGN_CHK_EN
            halt = (redirect_pc[1:0] != 2'b00);
`endif
        end
        last_acc = acc;
        last_rsp = rsp;
    endtask

    task automatic reset_for(input int n);
        rst = 1'b0;
        mq.delete(); fl.delete(); sb.delete();
        m_pc = RST_PC; halt = 1'b0; epoch++;
        first_acc_cyc = -1; first_valid_cyc = -1; watch_on = 1'b0;
        repeat (n) step();
        rel_pending = 1'b1;
    endtask

    task automatic redirect_and_watch(input logic [31:0] tgt, input logic [31:0] expect_pc);
        redir_go  = 1'b1;
        redir_tgt = tgt;
        step();
        watch_pc = expect_pc;
        watch_on = 1'b1;
    endtask

    initial begin
        int p0, a0;
        bit found;
        rst = 1'b0;

        // Reset state, then 1-cycle memory at full rate.
        rdy_mode = 0; irdy_mode = 0; lat_min = 1; lat_max = 1; redir_rate = 0;
        reset_for(3);
        watch_pc = RST_PC; watch_on = 1'b1;
        repeat (10) step();
        chk((first_valid_cyc - first_acc_cyc) == 2, "first_instr_latency",
            32'(first_valid_cyc - first_acc_cyc), 32'd2);
        p0 = pops;
        repeat (20) step();
        chk((pops - p0) == 20, "steady_throughput", 32'(pops - p0), 32'd20);

        // Decoder stalled: credit caps requests, nothing lost afterwards.
        irdy_mode = 2;
        reset_for(2);
        a0 = accepts;
        repeat (10) step();
        chk((accepts - a0) <= QD, "stall_accept_cap", 32'(accepts - a0), 32'(QD));
        chk(mem_req_valid == 1'b0, "stall_req_valid_low", {31'b0, mem_req_valid}, 32'h0);
        chk(instr_valid && instr_pc == 32'h0, "stall_head_pc", instr_pc, 32'h0);
        irdy_mode = 0;
        repeat (20) step();

        // Toggling request ready with 3-cycle latency.
        rdy_mode = 2; lat_min = 3; lat_max = 3;
        reset_for(2);
        p0 = pops;
        repeat (40) step();
        chk((pops - p0) >= 8, "toggle_progress", 32'(pops - p0), 32'd8);

        // Redirect with two requests outstanding.
        rdy_mode = 0;
        reset_for(2);
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            step();
            if (fl.size() == 2) found = 1'b1;
        end
        chk(found, "two_outstanding_reached", {31'b0, found}, 32'h1);
        redirect_and_watch(32'h0000_0200, 32'h0000_0200);
        repeat (20) step();
        chk(watch_on == 1'b0, "redirect_200_delivered", {31'b0, watch_on}, 32'h0);

        // Redirect coinciding with an accept and a response.
        lat_min = 1; lat_max = 1;
        repeat (10) step();
        redir_go = 1'b1; redir_tgt = 32'h0000_0500;
        step();
        chk(last_acc && last_rsp, "redirect_with_acc_and_rsp", {30'b0, last_acc, last_rsp}, 32'h3);
        watch_pc = 32'h0000_0500; watch_on = 1'b1;
        repeat (20) step();
        chk(watch_on == 1'b0, "redirect_500_delivered", {31'b0, watch_on}, 32'h0);

`ifdef IFETCH_MISALIGN_CHK_EN
        redir_go = 1'b1; redir_tgt = 32'h0000_0302;
        step();
        repeat (5) step();
        chk(misaligned_err == 1'b1, "misalign_set", {31'b0, misaligned_err}, 32'h1);
        chk(mem_req_valid == 1'b0, "misalign_halts_fetch", {31'b0, mem_req_valid}, 32'h0);
        redirect_and_watch(32'h0000_0400, 32'h0000_0400);
        repeat (10) step();
        chk(misaligned_err == 1'b0, "misalign_cleared", {31'b0, misaligned_err}, 32'h0);
        chk(watch_on == 1'b0, "resume_at_400", {31'b0, watch_on}, 32'h0);
`else
        redirect_and_watch(32'h0000_0302, 32'h0000_0300);
        repeat (10) step();
        chk(watch_on == 1'b0, "low_bits_masked", {31'b0, watch_on}, 32'h0);
`endif

        // Randomised traffic with redirects and a mid-run reset.
        rdy_mode = 1; irdy_mode = 1; lat_min = 1; lat_max = 4; redir_rate = 30;
        repeat (1500) step();
        redir_rate = 0;
        reset_for(2);
        redir_rate = 30;
        repeat (1500) step();
        redir_rate = 0; rdy_mode = 0; irdy_mode = 0;
        repeat (30) step();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
